// File: rtl/vt_text_pkg.sv
// Shared types and constants for the terminal text writer.
package vt_text_pkg;

  // Writer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_CLR
  } tw_state_e;

  // Control codes interpreted by the writer
  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  // Text-area heights selected by lmode, and the default row width
  localparam int ROWS_L0      = 24;
  localparam int ROWS_L1      = 38;
  localparam int COLS_DEFAULT = 80;

endpackage

// File: rtl/vt_text_writer_if.sv
// Wishbone classic bus between the text writer (master) and the VRAM slave.
interface vt_text_writer_if;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/vt_wb_single_master.sv
// One-transfer Wishbone classic engine: latches a request, holds cyc/stb
// until ack, then releases the bus for at least one cycle.
module vt_wb_single_master (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  vt_text_writer_if.master wb,
  input  logic             req,
  input  logic             we,
  input  logic [15:0]      adr,
  input  logic [1:0]       sel,
  input  logic [15:0]      dat,
  output logic             done,
  output logic [15:0]      rdata
);

  // Completion is the ack edge itself, so the caller advances in step with cyc dropping
  assign done = wb.wb_cyc_o & wb.wb_stb_o & wb.wb_ack_i;

  // Bus cycle register: start on req while idle, end on ack, capture read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= 2'b00;
      wb.wb_adr_o <= 16'h0000;
      wb.wb_dat_o <= 16'h0000;
      rdata       <= 16'h0000;
    end else if (wb.wb_cyc_o) begin
      if (wb.wb_ack_i) begin
        wb.wb_cyc_o <= 1'b0;
        wb.wb_stb_o <= 1'b0;
        if (!wb.wb_we_o) rdata <= wb.wb_dat_i;
      end
    end else if (req) begin
      wb.wb_cyc_o <= 1'b1;
      wb.wb_stb_o <= 1'b1;
      wb.wb_we_o  <= we;
      wb.wb_sel_o <= sel;
      wb.wb_adr_o <= adr;
      wb.wb_dat_o <= dat;
    end
  end

endmodule

// File: rtl/vt_text_writer.sv
// Terminal text writer: decodes a byte stream (CR/LF/BS/FF/printables),
// tracks the cursor and writes VRAM over Wishbone, scrolling by word copy.
// Rows below TOP_ROW form the service area and are never written.
// Build option: define TEXT_WRITER_AUTOWRAP_EN to wrap printables at the
// last column onto the next line (scrolling at the bottom); otherwise the
// column saturates and the last cell is overwritten.
module vt_text_writer
  import vt_text_pkg::*;
#(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter int          COLS      = COLS_DEFAULT,
  parameter int          TOP_ROW   = 2,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  vt_text_writer_if.master wb,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lmode,
  output logic [12:0]      cursor,
  output logic             busy
);

  localparam logic [12:0] TOP_ADDR = 13'(TOP_ROW * COLS);
  localparam logic [6:0]  COL_MAX  = 7'(COLS - 1);

  tw_state_e   state, state_nx;
  logic [5:0]  row, last_q, last_now, row_eff;
  logic [6:0]  col;
  logic [12:0] ptr, ptr_nx, cur_addr, copy_end, clr_end, vaddr;
  logic [7:0]  code_q;
  logic        home_q;
  logic        req, we, done;
  logic [1:0]  sel;
  logic [15:0] wdat, rdata;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Bottom row for the lmode seen now; a row left beyond it is pulled back
  assign last_now = 6'(TOP_ROW + (lmode ? ROWS_L1 : ROWS_L0) - 1);
  assign row_eff  = (row > last_now) ? last_now : row;

  assign cur_addr = 13'(row) * 13'(COLS) + 13'(col);
  assign copy_end = 13'(last_q) * 13'(COLS);
  assign clr_end  = copy_end + 13'(COLS);
  assign ptr_nx   = ptr + 13'd2;

  vt_wb_single_master u_wb (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb       (wb),
    .req      (req),
    .we       (we),
    .adr      (BASE_ADR + {3'b000, vaddr}),
    .sel      (sel),
    .dat      (wdat),
    .done     (done),
    .rdata    (rdata)
  );

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state and bus request for the current state
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    we       = 1'b0;
    vaddr    = ptr;
    sel      = 2'b11;
    wdat     = {FILL_CHAR, FILL_CHAR};
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20)                              state_nx = ST_PUT;
          else if (in_data == CODE_LF && row_eff >= last_now) state_nx = ST_SCR_RD;
          else if (in_data == CODE_FF)                        state_nx = ST_CLR;
        end
      end
      ST_PUT: begin
        req   = 1'b1;
        we    = 1'b1;
        vaddr = cur_addr;
        sel   = cur_addr[0] ? 2'b10 : 2'b01;
        wdat  = {code_q, code_q};
        if (done) begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
          state_nx = (col == COL_MAX && row >= last_q) ? ST_SCR_RD : ST_IDLE;
`else
          state_nx = ST_IDLE;
`endif
        end
      end
      ST_SCR_RD: begin
        req   = 1'b1;
        vaddr = ptr + 13'(COLS);
        if (done) state_nx = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        req  = 1'b1;
        we   = 1'b1;
        wdat = rdata;
        if (done) state_nx = (ptr_nx == copy_end) ? ST_CLR : ST_SCR_RD;
      end
      ST_CLR: begin
        req = 1'b1;
        we  = 1'b1;
        if (done && ptr_nx == clr_end) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Row/column counters, copy pointer and per-byte latched context
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      row    <= 6'(TOP_ROW);
      col    <= 7'd0;
      ptr    <= TOP_ADDR;
      last_q <= 6'(TOP_ROW + ROWS_L0 - 1);
      code_q <= 8'h00;
      home_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            last_q <= last_now;
            code_q <= in_data;
            home_q <= 1'b0;
            ptr    <= TOP_ADDR;
            if (in_data >= 8'h20) begin
              row <= row_eff;
            end else begin
              case (in_data)
                CODE_CR: col <= 7'd0;
                CODE_BS: if (col != 7'd0) col <= col - 7'd1;
                CODE_LF: row <= (row_eff < last_now) ? row_eff + 6'd1 : row_eff;
                CODE_FF: home_q <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        ST_PUT: begin
          if (done) begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
            if (col == COL_MAX) begin
              col <= 7'd0;
              if (row < last_q) row <= row + 6'd1;
            end else begin
              col <= col + 7'd1;
            end
`else
            if (col != COL_MAX) col <= col + 7'd1;
`endif
          end
        end
        ST_SCR_WR: if (done) ptr <= ptr_nx;
        ST_CLR: begin
          if (done) begin
            ptr <= ptr_nx;
            if (ptr_nx == clr_end && home_q) begin
              row <= 6'(TOP_ROW);
              col <= 7'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Cursor output follows the counters one cycle later
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cursor <= TOP_ADDR;
    else          cursor <= cur_addr;
  end

endmodule

// File: tb/tb_vt_text_writer.sv
// Scoreboard bench for vt_text_writer: expected VRAM writes are queued as
// bytes are sent; a monitor pops one entry per completed write transfer.
module tb_vt_text_writer;

  localparam int COLS  = 80;
  localparam int BOUND = 20000;

  typedef struct {
    logic [15:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
  } exp_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        in_valid = 1'b0;
  logic        lmode    = 1'b0;
  logic        in_ready, busy;
  logic [12:0] cursor;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr = 0;
  int   n_rd = 0;
  logic sb_en = 1'b1;
  logic do_fill = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mem [0:4095];

  always #5 wb_clk_i = ~wb_clk_i;

  vt_text_writer_if wb ();

  vt_text_writer #(
    .BASE_ADR (16'h0000),
    .COLS     (COLS),
    .TOP_ROW  (2),
    .FILL_CHAR(8'h20)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb       (wb),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .lmode    (lmode),
    .cursor   (cursor),
    .busy     (busy)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + i / 256 + 3);
  endfunction

  // VRAM slave: registered ack over a 4 KB byte array
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb.wb_ack_i <= 1'b0;
      wb.wb_dat_i <= 16'h0000;
    end else begin
      if (do_fill) for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      if (wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i) begin
        wb.wb_ack_i <= 1'b1;
        if (wb.wb_we_o) begin
          if (wb.wb_sel_o[0]) mem[{wb.wb_adr_o[11:1], 1'b0}] <= wb.wb_dat_o[7:0];
          if (wb.wb_sel_o[1]) mem[{wb.wb_adr_o[11:1], 1'b1}] <= wb.wb_dat_o[15:8];
        end else begin
          wb.wb_dat_i <= {mem[{wb.wb_adr_o[11:1], 1'b1}], mem[{wb.wb_adr_o[11:1], 1'b0}]};
        end
      end else begin
        wb.wb_ack_i <= 1'b0;
      end
    end
  end

  // Monitor: each acked write is compared against the head of the queue
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
      if (wb.wb_we_o) begin
        n_wr++;
        if (sb_en) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL wr_extra: got adr=%h sel=%b dat=%h, expected no write",
                     wb.wb_adr_o, wb.wb_sel_o, wb.wb_dat_o);
          end else begin
            mon_e = exp_q.pop_front();
            if (wb.wb_adr_o !== mon_e.adr || wb.wb_sel_o !== mon_e.sel || wb.wb_dat_o !== mon_e.dat) begin
              n_errors++;
              $display("FAIL wr: got adr=%h sel=%b dat=%h, expected adr=%h sel=%b dat=%h",
                       wb.wb_adr_o, wb.wb_sel_o, wb.wb_dat_o, mon_e.adr, mon_e.sel, mon_e.dat);
            end
          end
        end
      end else begin
        n_rd++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int adr, input logic [1:0] sel, input logic [15:0] dat);
    exp_t e;
    e.adr = 16'(adr);
    e.sel = sel;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input int adr, input logic [7:0] c);
    push_wr(adr, (adr % 2 == 1) ? 2'b10 : 2'b01, {c, c});
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    in_valid = 1'b0;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    exp_q.delete();
    @(negedge wb_clk_i);
  endtask

  task automatic fill_mem();
    @(negedge wb_clk_i);
    do_fill = 1'b1;
    @(negedge wb_clk_i);
    do_fill = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge wb_clk_i);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < BOUND) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (t >= BOUND) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", t);
    end
    @(negedge wb_clk_i);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge wb_clk_i);
    while ((busy || !in_ready) && t < BOUND) begin
      @(negedge wb_clk_i);
      t++;
    end
    check({name, "_idle"}, 32'(t < BOUND), 32'd1);
    @(negedge wb_clk_i);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int bad, wr0, rd0, t;
    logic [7:0] c;

    // 1: reset state, single printable
    do_reset();
    check("rst_cursor", 32'(cursor), 32'd160);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cyc_stb_we", {29'd0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 32'd0);
    check("rst_sel", 32'(wb.wb_sel_o), 32'd0);
    check("rst_adr_dat", {wb.wb_adr_o, wb.wb_dat_o}, 32'd0);
    push_wr(160, 2'b01, 16'h4141);
    send_byte(8'h41);
    wait_idle("t1");
    check("t1_cursor", 32'(cursor), 32'd161);
    check("t1_mem160", 32'(mem[160]), 32'h41);

    // 2: back-to-back bytes, CR, BS at column 0
    do_reset();
    push_wr(160, 2'b01, 16'h4141);
    push_wr(161, 2'b10, 16'h4242);
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle("t2");
    check("t2_mem160", 32'(mem[160]), 32'h41);
    check("t2_mem161", 32'(mem[161]), 32'h42);
    check("t2_cursor_ab", 32'(cursor), 32'd162);
    send_byte(8'h0D);
    wait_idle("t2_cr");
    check("t2_cursor_cr", 32'(cursor), 32'd160);
    send_byte(8'h08);
    wait_idle("t2_bs");
    check("t2_cursor_bs", 32'(cursor), 32'd160);

    // 3: LF on the last row (lmode=0) scrolls rows 3..25 up and clears row 25
    do_reset();
    lmode = 1'b0;
    repeat (23) send_byte(8'h0A);
    wait_idle("t3_lf");
    check("t3_cursor_row25", 32'(cursor), 32'd2000);
    fill_mem();
    for (int k = 0; k < 920; k++)
      push_wr(160 + 2 * k, 2'b11, {pat(160 + 2 * k + 81), pat(160 + 2 * k + 80)});
    for (int k = 0; k < 40; k++) push_wr(2000 + 2 * k, 2'b11, 16'h2020);
    send_byte(8'h0A);
    wait_idle("t3");
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[i] !== pat(i)) bad++;
    check("t3_rows01_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 160; i < 2000; i++) if (mem[i] !== pat(i + 80)) bad++;
    check("t3_copy_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 2000; i < 2080; i++) if (mem[i] !== 8'h20) bad++;
    check("t3_row25_bad", 32'(bad), 32'd0);
    check("t3_cursor", 32'(cursor), 32'd2000);

    // 4: FF with lmode=1 clears rows 2..39 and homes the cursor
    do_reset();
    lmode = 1'b1;
    fill_mem();
    send_byte(8'h0A);
    send_byte(8'h0A);
    wait_idle("t4_lf");
    check("t4_cursor_row4", 32'(cursor), 32'd320);
    wr0 = n_wr;
    rd0 = n_rd;
    for (int k = 0; k < 1520; k++) push_wr(160 + 2 * k, 2'b11, 16'h2020);
    send_byte(8'h0C);
    wait_idle("t4");
    bad = 0;
    for (int i = 160; i < 3200; i++) if (mem[i] !== 8'h20) bad++;
    check("t4_clear_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[i] !== pat(i)) bad++;
    check("t4_service_bad", 32'(bad), 32'd0);
    check("t4_cursor", 32'(cursor), 32'd160);
    check("t4_writes", 32'(n_wr - wr0), 32'd1520);
    check("t4_reads", 32'(n_rd - rd0), 32'd0);

    // 5: 82 printables from column 0 of row 2
    do_reset();
    lmode = 1'b0;
    for (int i = 0; i < 82; i++) begin
      c = 8'h41 + 8'(i % 26);
`ifdef TEXT_WRITER_AUTOWRAP_EN
      push_byte((i < 80) ? 160 + i : 240 + (i - 80), c);
`else
      push_byte((i < 80) ? 160 + i : 239, c);
`endif
      send_byte(c);
    end
    wait_idle("t5");
    c = 8'h41 + 8'(81 % 26);
`ifdef TEXT_WRITER_AUTOWRAP_EN
    check("t5_cursor", 32'(cursor), 32'd242);
    check("t5_mem241", 32'(mem[241]), 32'(c));
`else
    check("t5_cursor", 32'(cursor), 32'd239);
    check("t5_mem239", 32'(mem[239]), 32'(c));
`endif

    // 7: row beyond the 24-row bottom after lmode 1->0 is clamped on a printable
    do_reset();
    lmode = 1'b1;
    repeat (30) send_byte(8'h0A);
    wait_idle("t7_lf");
    check("t7_cursor_row32", 32'(cursor), 32'd2560);
    lmode = 1'b0;
    push_wr(2000, 2'b01, 16'h5a5a);
    send_byte(8'h5A);
    wait_idle("t7");
    check("t7_cursor", 32'(cursor), 32'd2001);

    // 6: reset in the middle of a scroll
    do_reset();
    lmode = 1'b0;
    sb_en = 1'b0;
    repeat (24) send_byte(8'h0A);
    repeat (40) @(negedge wb_clk_i);
    t = 0;
    while (!wb.wb_cyc_o && t < 100) begin
      @(negedge wb_clk_i);
      t++;
    end
    check("t6_in_transfer", 32'(wb.wb_cyc_o), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    check("t6_cyc_stb_drop", {30'd0, wb.wb_cyc_o, wb.wb_stb_o}, 32'd0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    exp_q.delete();
    @(negedge wb_clk_i);
    sb_en = 1'b1;
    check("t6_cursor", 32'(cursor), 32'd160);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Last-resort guard against a stalled run
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
